signal_emitter: RTL and testbench



---
 rtl/signal_emitter_pkg.sv | 27 ++
 rtl/signal_emitter_timer.sv | 88 ++++++++
 rtl/signal_emitter.sv | 175 +++++++++++++++++
 tb/tb_signal_emitter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/signal_emitter_pkg.sv
// Shared definitions for the signal emitter and its oversampling capture counterpart.
// Holds the FSM state encoding, the default bit-period timing shared with the capture
// block, the minimum preamble length, and small elaboration helpers.
package signal_emitter_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StPreamble = 2'd1,
    StData     = 2'd2
  } state_e;

  // Mid-bit tick index for a given period length.
  function automatic int unsigned half_of(input int unsigned rate);
    return (rate - 1) >> 1;
  endfunction

  // Counter width for 0..n-1, never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned ClockRateDefault = 12;
  localparam int unsigned HalfDefault      = half_of(ClockRateDefault);
  // Five toggling periods give the receiver four clean edges to lock on.
  localparam int unsigned PreambleMin      = 5;

endpackage

// File: rtl/signal_emitter_timer.sv
// Bit-period timer for the signal emitter.
// Runs the per-period tick counter while the emitter is active, flags the last tick of
// a period (the next ce edge starts a new period) and the edge that lands on the
// mid-bit tick of a data period.
// Optional feature (macro SIGNAL_EMITTER_DRIFT_EN): every DRIFT_PERIOD-th data period
// is stretched by one tick to exercise receiver phase tracking.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   ce           : clock enable, state advances only when high
//   run_i        : emitter is in preamble or data (counter held at 0 otherwise)
//   data_i       : emitter is sending data bits
//   last_tick_o  : current tick is the final one of the period
//   mid_next_o   : this ce edge moves a data period onto its mid-bit tick
module signal_emitter_timer
  import signal_emitter_pkg::*;
#(
  parameter int unsigned CLOCK_RATE = ClockRateDefault,
  parameter int unsigned HALF       = half_of(CLOCK_RATE),
  parameter int unsigned BITS_COUNT = 4
`ifdef SIGNAL_EMITTER_DRIFT_EN
  ,
  parameter int unsigned DRIFT_PERIOD = 16
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic ce,
  input  logic run_i,
  input  logic data_i,
  output logic last_tick_o,
  output logic mid_next_o
);

  logic [BITS_COUNT-1:0] count_q, count_d;
  logic                  stretch;

`ifdef SIGNAL_EMITTER_DRIFT_EN
  localparam int unsigned DriftW = clog2_min1(DRIFT_PERIOD);

  // Index of the current data period modulo DRIFT_PERIOD; carries across back-to-back
  // words and clears whenever the emitter is not in DATA.
  logic [DriftW-1:0] drift_q, drift_d;

  assign stretch = data_i && (drift_q == DriftW'(DRIFT_PERIOD - 1));

  always_comb begin
    drift_d = drift_q;
    if (ce) begin
      if (!data_i) begin
        drift_d = '0;
      end else if (last_tick_o) begin
        drift_d = stretch ? '0 : drift_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drift_q <= '0;
    end else begin
      drift_q <= drift_d;
    end
  end
`else
  assign stretch = 1'b0;
`endif

  assign last_tick_o = run_i &&
      (count_q == (stretch ? BITS_COUNT'(CLOCK_RATE) : BITS_COUNT'(CLOCK_RATE - 1)));

  always_comb begin
    count_d = count_q;
    if (ce) begin
      count_d = (last_tick_o || !run_i) ? '0 : count_q + 1'b1;
    end
  end

  assign mid_next_o = ce && data_i && (count_d == BITS_COUNT'(HALF));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/signal_emitter.sv
// Serial signal emitter: sends parallel words MSB first on a single registered line,
// each bit held for CLOCK_RATE clock-enabled cycles, with a toggling preamble before
// every burst so the far-end capture unit can lock. Words offered on the final tick of
// a word stream back-to-back with no preamble.
// Optional feature (macro SIGNAL_EMITTER_DRIFT_EN): periodic one-tick period stretch,
// implemented in signal_emitter_timer; exposes parameter DRIFT_PERIOD.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   ce         : clock enable, all state advances only when high
//   tdata      : word to send, MSB first; tvalid marks it valid
//   tready     : word accepted this cycle when tvalid is also high (combinational)
//   d          : serial line (registered)
//   busy       : preamble or data in progress
//   bit_strobe : one-clk pulse at mid-bit of each data bit
//   strobe_bit : data bit on d, valid with bit_strobe
module signal_emitter
  import signal_emitter_pkg::*;
#(
  parameter int unsigned CLOCK_RATE = ClockRateDefault,
  parameter int unsigned HALF       = half_of(CLOCK_RATE),
  parameter int unsigned BITS_COUNT = 4,
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned PREAMBLE   = 6
`ifdef SIGNAL_EMITTER_DRIFT_EN
  ,
  parameter int unsigned DRIFT_PERIOD = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [WIDTH-1:0] tdata,
  input  logic             tvalid,
  output logic             tready,
  output logic             d,
  output logic             busy,
  output logic             bit_strobe,
  output logic             strobe_bit
);

  localparam int unsigned IdxW = clog2_min1(WIDTH);
  localparam int unsigned PreW = clog2_min1(PREAMBLE);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [IdxW-1:0]  bitidx_q, bitidx_d;
  logic [PreW-1:0]  pcount_q, pcount_d;
  logic             d_q, d_d;
  logic             bit_strobe_q, bit_strobe_d;
  logic             strobe_bit_q, strobe_bit_d;
  logic             last_tick, mid_next, last_bit, period_end, pre_done, xfer;

  signal_emitter_timer #(
    .CLOCK_RATE  (CLOCK_RATE),
    .HALF        (HALF),
    .BITS_COUNT  (BITS_COUNT)
`ifdef SIGNAL_EMITTER_DRIFT_EN
    ,
    .DRIFT_PERIOD(DRIFT_PERIOD)
`endif
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .run_i      (state_q != StIdle),
    .data_i     (state_q == StData),
    .last_tick_o(last_tick),
    .mid_next_o (mid_next)
  );

  assign last_bit   = (bitidx_q == IdxW'(WIDTH - 1));
  assign pre_done   = (pcount_q == PreW'(PREAMBLE - 1));
  // The next ce edge begins a new bit period.
  assign period_end = ce && last_tick;
  assign xfer       = tvalid && tready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (xfer) state_d = StPreamble;
      StPreamble: if (period_end && pre_done) state_d = StData;
      StData:     if (period_end && last_bit && !xfer) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy   = (state_q != StIdle);
    // Accept only when idle or on the final tick of the last bit of a word.
    tready = !rst && ce &&
             ((state_q == StIdle) || ((state_q == StData) && last_tick && last_bit));
  end

  // Datapath next-state
  always_comb begin
    shift_d  = shift_q;
    bitidx_d = bitidx_q;
    pcount_d = pcount_q;
    d_d      = d_q;
    unique case (state_q)
      StIdle: begin
        if (xfer) begin
          // The toggle on accept is preamble period one.
          shift_d  = tdata;
          pcount_d = '0;
          bitidx_d = '0;
          d_d      = !d_q;
        end
      end
      StPreamble: begin
        if (period_end) begin
          if (pre_done) begin
            d_d      = shift_q[WIDTH-1];
            bitidx_d = '0;
          end else begin
            pcount_d = pcount_q + 1'b1;
            d_d      = !d_q;
          end
        end
      end
      StData: begin
        if (period_end) begin
          if (!last_bit) begin
            shift_d  = {shift_q[WIDTH-2:0], 1'b0};
            d_d      = shift_q[WIDTH-2];
            bitidx_d = bitidx_q + 1'b1;
          end else if (xfer) begin
            // Back-to-back word: continuous line, no preamble.
            shift_d  = tdata;
            d_d      = tdata[WIDTH-1];
            bitidx_d = '0;
          end
        end
      end
      default: ;
    endcase
    // mid_next is low whenever ce is low, so the strobe self-clears after one clk.
    bit_strobe_d = mid_next;
    strobe_bit_d = mid_next ? d_q : strobe_bit_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q      <= '0;
      bitidx_q     <= '0;
      pcount_q     <= '0;
      d_q          <= 1'b0;
      bit_strobe_q <= 1'b0;
      strobe_bit_q <= 1'b0;
    end else begin
      shift_q      <= shift_d;
      bitidx_q     <= bitidx_d;
      pcount_q     <= pcount_d;
      d_q          <= d_d;
      bit_strobe_q <= bit_strobe_d;
      strobe_bit_q <= strobe_bit_d;
    end
  end

  assign d          = d_q;
  assign bit_strobe = bit_strobe_q;
  assign strobe_bit = strobe_bit_q;

endmodule

// File: tb/tb_signal_emitter.sv
// Self-checking bench for signal_emitter. The reference model lays out the expected
// line waveform per ce-cycle from the burst rules (preamble toggles, MSB-first bits,
// optional stretched periods) and the bench compares the DUT against it cycle by cycle.
module tb_signal_emitter;
  localparam int unsigned Cr   = 12;
  localparam int unsigned Half = 5;
  localparam int unsigned Pre  = 6;
  localparam int unsigned W    = 8;
`ifdef SIGNAL_EMITTER_DRIFT_EN
  localparam int unsigned DriftPeriod = 4;
`else
  localparam int unsigned DriftPeriod = 0;
`endif

  logic         clk    = 1'b0;
  logic         rst    = 1'b1;
  logic         ce     = 1'b0;
  logic         tvalid = 1'b0;
  logic [W-1:0] tdata  = '0;
  logic         tready, d, busy, bit_strobe, strobe_bit;

  int unsigned  n_checks = 0;
  int unsigned  n_errors = 0;
  logic [W-1:0] words [64];
  bit           exp_d[$];
  bit           exp_busy[$];
  bit           exp_stb[$];
  bit           exp_tr[$];
  bit           d_model = 1'b0;

  always #5 clk = ~clk;

  signal_emitter #(
    .CLOCK_RATE  (Cr),
    .HALF        (Half),
    .BITS_COUNT  (4),
    .WIDTH       (W),
    .PREAMBLE    (Pre)
`ifdef SIGNAL_EMITTER_DRIFT_EN
    ,
    .DRIFT_PERIOD(DriftPeriod)
`endif
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .tdata     (tdata),
    .tvalid    (tvalid),
    .tready    (tready),
    .d         (d),
    .busy      (busy),
    .bit_strobe(bit_strobe),
    .strobe_bit(strobe_bit)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic void push_cycle(input bit v, input bit stb, input bit tr);
    exp_d.push_back(v);
    exp_busy.push_back(1'b1);
    exp_stb.push_back(stb);
    exp_tr.push_back(tr);
  endfunction

  // Expected waveform for a burst of nwords, one entry per ce-cycle after the accept.
  function automatic void build_model(input int nwords);
    bit v = d_model;
    int n = 0;
    int len;
    int dp = (DriftPeriod == 0) ? 32'h4000_0000 : int'(DriftPeriod);
    exp_d.delete();
    exp_busy.delete();
    exp_stb.delete();
    exp_tr.delete();
    for (int p = 0; p < int'(Pre); p++) begin
      v = !v;
      for (int c = 0; c < int'(Cr); c++) push_cycle(v, 1'b0, 1'b0);
    end
    for (int w = 0; w < nwords; w++) begin
      for (int j = int'(W) - 1; j >= 0; j--) begin
        v = words[w][j];
        n++;
        len = (n % dp == 0) ? int'(Cr) + 1 : int'(Cr);
        for (int c = 0; c < len; c++) push_cycle(v, c == int'(Half), (c == len - 1) && (j == 0));
      end
    end
    d_model = v;
  endfunction

  function automatic bit exp_d_at(input int i);
    return (i < exp_d.size()) ? exp_d[i] : d_model;
  endfunction

  // Send words[0..nwords-1] with ce high once every ce_div clocks; stop early at step
  // stop_at when it is non-negative.
  task automatic run_stream(input int nwords, input int ce_div, input int stop_at);
    int wi = 0;
    int total;
    bit e_tr;
    bit xfer;
    build_model(nwords);
    total  = exp_d.size();
    tdata  = words[0];
    tvalid = 1'b1;
    for (int s = 0; s < total + 4; s++) begin
      if (stop_at >= 0 && s == stop_at) break;
      e_tr = (s == 0 || s - 1 >= total) ? 1'b1 : exp_tr[s-1];
      for (int i = 1; i < ce_div; i++) begin
        ce = 1'b0;
        #1;
        check("tready_ce_low", tready, 1'b0);
        @(posedge clk);
        #1;
        check("strobe_ce_low", bit_strobe, 1'b0);
        if (s > 0) check("d_hold_ce_low", d, exp_d_at(s - 1));
      end
      ce = 1'b1;
      #1;
      check("tready", tready, e_tr);
      xfer = tvalid && e_tr;
      @(posedge clk);
      #1;
      if (xfer) begin
        wi++;
        if (wi < nwords) begin
          tdata = words[wi];
        end else begin
          tvalid = 1'b0;
          tdata  = W'($urandom);
        end
      end
      check("d", d, exp_d_at(s));
      check("busy", busy, (s < total) ? exp_busy[s] : 1'b0);
      check("bit_strobe", bit_strobe, (s < total) ? exp_stb[s] : 1'b0);
      if (s < total && exp_stb[s]) check("strobe_bit", strobe_bit, exp_d[s]);
    end
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      ce     = 1'($urandom_range(0, 1));
      tvalid = 1'b0;
      tdata  = W'($urandom);
      #1;
      check("idle_tready", tready, ce);
      @(posedge clk);
      #1;
      check("idle_busy", busy, 1'b0);
      check("idle_d", d, d_model);
      check("idle_strobe", bit_strobe, 1'b0);
    end
  endtask

  initial begin
    int sent = 0;
    int nw;
    rst    = 1'b1;
    ce     = 1'b1;
    tvalid = 1'b1;
    tdata  = 8'hA5;
    repeat (2) @(posedge clk);
    #1;
    check("rst_d", d, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_strobe", bit_strobe, 1'b0);
    check("rst_strobe_bit", strobe_bit, 1'b0);
    check("rst_tready", tready, 1'b0);
    #2;
    rst    = 1'b0;
    tvalid = 1'b0;
    idle_gap(4);

    // Single word at full rate
    words[0] = 8'hA5;
    run_stream(1, 1, -1);
    idle_gap(3);

    // Back-to-back words
    words[0] = 8'hFF;
    words[1] = 8'h00;
    run_stream(2, 1, -1);
    idle_gap(3);

    // ce every third clock
    words[0] = 8'hA5;
    run_stream(1, 3, -1);
    idle_gap(3);

    // Asynchronous reset inside the fourth data bit
    words[0] = 8'hFF;
    run_stream(1, 1, int'(Pre * Cr + 3 * Cr + 5));
    check("pre_reset_d", d, 1'b1);
    check("pre_reset_busy", busy, 1'b1);
    tvalid = 1'b0;
    ce     = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_d", d, 1'b0);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_tready", tready, 1'b0);
    check("async_rst_strobe", bit_strobe, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("post_rst_tready_ce1", tready, 1'b1);
    ce = 1'b0;
    #1;
    check("post_rst_tready_ce0", tready, 1'b0);
    check("post_rst_d", d, 1'b0);
    d_model = 1'b0;
    idle_gap(3);

    // Randomized bursts, 32 words total
    while (sent < 32) begin
      nw = int'($urandom_range(1, 8));
      if (nw > 32 - sent) nw = 32 - sent;
      for (int i = 0; i < nw; i++) words[i] = W'($urandom);
      run_stream(nw, int'($urandom_range(1, 3)), -1);
      idle_gap(int'($urandom_range(1, 10)));
      sent += nw;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
